// File: rtl/gmii_pkg.sv
// gmii_pkg: shared definitions for the GMII receive path.
// Holds the receiver FSM state encoding, the framing byte values, the
// CRC-32 constants and the bit positions inside the out_err status vector.
package gmii_pkg;

  typedef enum logic [2:0] {
    WAIT = 3'd0,
    IDLE = 3'd1,
    PRE  = 3'd2,
    DATA = 3'd3,
    DROP = 3'd4
  } state_e;

  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // out_err bit positions
  localparam int ERR_FCS = 0;  // FCS mismatch
  localparam int ERR_PHY = 1;  // phy_err seen, runt or bad preamble
  localparam int ERR_LEN = 2;  // over-length

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational byte-parallel CRC-32 update (reflected, LSB first).
// Ports:
//   crc_i  in  32  current CRC register
//   dat_i  in  8   byte to absorb
//   crc_o  out 32  CRC register after absorbing dat_i
module crc32_d8
  import gmii_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  dat_i,
  output logic [31:0] crc_o
);

  logic [31:0] c_s;

  // Unrolled eight-step shift of the reflected LFSR.
  always_comb begin
    c_s = crc_i ^ {24'h000000, dat_i};
    for (int i = 0; i < 8; i++) begin
      if (c_s[0]) begin
        c_s = (c_s >> 1) ^ CRC_POLY;
      end else begin
        c_s = c_s >> 1;
      end
    end
    crc_o = c_s;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// gmii_rx_frame: byte-wide GMII frame receiver.
// Strips preamble/SFD, emits the payload with the 4-byte FCS removed,
// checks CRC-32 and reports one end-of-frame status per frame.
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   synchronous active-low reset
//   phy_val   in  1   GMII data valid
//   phy_err   in  1   GMII error
//   phy_dat   in  8   GMII byte
//   out_dat   out 8   payload byte
//   out_val   out 1   out_dat valid
//   out_sof   out 1   first payload byte of the frame
//   out_eof   out 1   end-of-frame status strobe
//   out_good  out 1   frame good (with out_eof)
//   out_len   out 16  payload length, FCS excluded (with out_eof)
//   out_err   out 3   {over-length, phy/runt/preamble, FCS} (with out_eof)
module gmii_rx_frame
  import gmii_pkg::*;
#(
  parameter int MAX_LEN = 1518,
  parameter int MAX_PRE = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phy_val,
  input  logic        phy_err,
  input  logic [7:0]  phy_dat,
  output logic [7:0]  out_dat,
  output logic        out_val,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_good,
  output logic [15:0] out_len,
  output logic [2:0]  out_err
);

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
  localparam logic [7:0]  MAX_PRE_W = 8'(MAX_PRE);

  state_e           state_q, state_d;
  logic [7:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]      crc_q, crc_d, crc_nxt_s;
  logic [15:0]      cnt_q, cnt_d, cnt_inc_s;
  logic [3:0][7:0]  dly_q, dly_d;
  logic [2:0]       fill_q, fill_d;
  logic [15:0]      emit_cnt_q, emit_cnt_d;
  logic [2:0]       err_q, err_d, eof_err_s;
  logic [7:0]       out_dat_q, out_dat_d;
  logic             out_val_q, out_val_d;
  logic             out_sof_q, out_sof_d;
  logic             out_eof_q, out_eof_d;
  logic             out_good_q, out_good_d;
  logic [15:0]      out_len_q, out_len_d;
  logic [2:0]       out_err_q, out_err_d;

  crc32_d8 u_crc (
    .crc_i (crc_q),
    .dat_i (phy_dat),
    .crc_o (crc_nxt_s)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    dly_d      = dly_q;
    fill_d     = fill_q;
    emit_cnt_d = emit_cnt_q;
    err_d      = err_q;
    out_dat_d  = 8'h00;
    out_val_d  = 1'b0;
    out_sof_d  = 1'b0;
    out_eof_d  = 1'b0;
    out_good_d = 1'b0;
    out_len_d  = 16'h0000;
    out_err_d  = 3'b000;
    eof_err_s  = 3'b000;
    cnt_inc_s  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    case (state_q)
      // Frame cut by reset: swallow it silently until the line goes idle.
      WAIT: begin
        if (!phy_val) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end

      IDLE: begin
        if (phy_val) begin
          err_d      = 3'b000;
          emit_cnt_d = 16'h0000;
          if (phy_dat == PRE_BYTE) begin
            state_d   = PRE;
            pre_cnt_d = 8'd1;
          end else begin
            state_d        = DROP;
            err_d[ERR_PHY] = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      PRE: begin
        if (phy_val) begin
          if ((phy_dat == PRE_BYTE) && (pre_cnt_q < MAX_PRE_W)) begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end else if (phy_dat == SFD_BYTE) begin
            state_d = DATA;
            crc_d   = CRC_INIT;
            cnt_d   = 16'h0000;
            dly_d   = '0;
            fill_d  = 3'd0;
          end else begin
            state_d        = DROP;
            err_d[ERR_PHY] = 1'b1;
          end
        end else begin
          // No SFD ever seen: not a frame, nothing to report.
          state_d = IDLE;
        end
      end

      DATA: begin
        if (phy_val) begin
          crc_d  = crc_nxt_s;
          dly_d  = {dly_q[2:0], phy_dat};
          fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
          cnt_d  = cnt_inc_s;
          if (phy_err) begin
            err_d[ERR_PHY] = 1'b1;
          end else begin
            err_d[ERR_PHY] = err_q[ERR_PHY];
          end
          if (cnt_inc_s > MAX_LEN_W) begin
            // The byte displaced now would follow the last legal one; stop here.
            err_d[ERR_LEN] = 1'b1;
            state_d        = DROP;
          end else if (fill_q == 3'd4) begin
            out_dat_d  = dly_q[3];
            out_val_d  = 1'b1;
            out_sof_d  = (emit_cnt_q == 16'h0000);
            emit_cnt_d = (emit_cnt_q == 16'hFFFF) ? emit_cnt_q : emit_cnt_q + 16'd1;
          end else begin
            out_val_d = 1'b0;
          end
        end else begin
          // End of frame: whatever sits in the delay line is the FCS.
          if (cnt_q < 16'd4) begin
            eof_err_s          = err_q;
            eof_err_s[ERR_PHY] = 1'b1;
            out_len_d          = 16'h0000;
          end else begin
            eof_err_s          = err_q;
            eof_err_s[ERR_FCS] = (crc_q != CRC_RESIDUE);
            out_len_d          = cnt_q - 16'd4;
          end
          out_eof_d  = 1'b1;
          out_err_d  = eof_err_s;
          out_good_d = (eof_err_s == 3'b000);
          state_d    = IDLE;
        end
      end

      DROP: begin
        if (!phy_val) begin
          out_eof_d  = 1'b1;
          out_good_d = 1'b0;
          out_err_d  = err_q;
          out_len_d  = emit_cnt_q;
          state_d    = IDLE;
        end else begin
          state_d = DROP;
        end
      end

      default: begin
        state_d = WAIT;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= WAIT;
      pre_cnt_q  <= 8'h00;
      crc_q      <= 32'h00000000;
      cnt_q      <= 16'h0000;
      dly_q      <= '0;
      fill_q     <= 3'd0;
      emit_cnt_q <= 16'h0000;
      err_q      <= 3'b000;
      out_dat_q  <= 8'h00;
      out_val_q  <= 1'b0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
      out_good_q <= 1'b0;
      out_len_q  <= 16'h0000;
      out_err_q  <= 3'b000;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      dly_q      <= dly_d;
      fill_q     <= fill_d;
      emit_cnt_q <= emit_cnt_d;
      err_q      <= err_d;
      out_dat_q  <= out_dat_d;
      out_val_q  <= out_val_d;
      out_sof_q  <= out_sof_d;
      out_eof_q  <= out_eof_d;
      out_good_q <= out_good_d;
      out_len_q  <= out_len_d;
      out_err_q  <= out_err_d;
    end
  end

  assign out_dat  = out_dat_q;
  assign out_val  = out_val_q;
  assign out_sof  = out_sof_q;
  assign out_eof  = out_eof_q;
  assign out_good = out_good_q;
  assign out_len  = out_len_q;
  assign out_err  = out_err_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb_gmii_rx_frame: self-checking bench for gmii_rx_frame (MAX_LEN=50).
// Table-driven frames plus hand-written corner sequences; expected payload
// bytes and end-of-frame records are queued when a frame is driven and
// compared when the DUT produces them.
module tb_gmii_rx_frame;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] dat;
    logic       sof;
    string      tag;
  } pay_t;

  typedef struct {
    logic        good;
    logic [15:0] len;
    logic [2:0]  err;
    string       tag;
  } eof_t;

  typedef struct {
    string      name;
    int         plen;
    int         npre;
    bit         ascii;
    bit         corrupt;
    int         err_pos;
    int         n_emit;
    logic       good;
    int         len;
    logic [2:0] err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        phy_val = 1'b0;
  logic        phy_err = 1'b0;
  logic [7:0]  phy_dat = 8'h00;
  logic [7:0]  out_dat;
  logic        out_val;
  logic        out_sof;
  logic        out_eof;
  logic        out_good;
  logic [15:0] out_len;
  logic [2:0]  out_err;

  int   errors = 0;
  int   checks = 0;
  pay_t exp_q[$];
  eof_t eof_q[$];
  vec_t vecs[9];

  gmii_rx_frame #(.MAX_LEN(50), .MAX_PRE(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .phy_val  (phy_val),
    .phy_err  (phy_err),
    .phy_dat  (phy_dat),
    .out_dat  (out_dat),
    .out_val  (out_val),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .out_good (out_good),
    .out_len  (out_len),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC-32; returns the FCS value (complemented).
  function automatic logic [31:0] fcs_of(input bq_t pl);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (pl[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pl[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  function automatic bq_t build(input bq_t pl, input int npre, input bit corrupt);
    bq_t fr;
    logic [31:0] f;
    fr = {};
    for (int i = 0; i < npre; i++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (pl[i]) fr.push_back(pl[i]);
    f = fcs_of(pl);
    fr.push_back(f[7:0]);
    fr.push_back(f[15:8]);
    fr.push_back(f[23:16]);
    fr.push_back(f[31:24]);
    if (corrupt) fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    return fr;
  endfunction

  task automatic expect_frame(input bq_t pl, input int n_emit, input logic good,
                              input int len, input logic [2:0] err, input string tag);
    pay_t p;
    eof_t e;
    for (int i = 0; i < n_emit; i++) begin
      p.dat = pl[i];
      p.sof = (i == 0);
      p.tag = tag;
      exp_q.push_back(p);
    end
    e.good = good;
    e.len  = 16'(len);
    e.err  = err;
    e.tag  = tag;
    eof_q.push_back(e);
  endtask

  task automatic send(input bq_t fr, input int err_idx, input int gap);
    for (int i = 0; i < fr.size(); i++) begin
      phy_val = 1'b1;
      phy_dat = fr[i];
      phy_err = (i == err_idx);
      @(posedge clk); #1;
    end
    phy_val = 1'b0;
    phy_err = 1'b0;
    phy_dat = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({out_dat, out_val, out_sof, out_eof, out_good, out_len, out_err} !== 31'd0) begin
      errors++;
      $display("FAIL %s: got dat=%h val=%b sof=%b eof=%b good=%b len=%0d err=%b, wanted all 0",
               tag, out_dat, out_val, out_sof, out_eof, out_good, out_len, out_err);
    end
  endtask

  // Scoreboard: compare every emitted byte and every end-of-frame status.
  always @(negedge clk) begin
    pay_t p;
    eof_t e;
    if (out_val) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL payload_extra: got dat=%h sof=%b, wanted no output", out_dat, out_sof);
      end else begin
        p = exp_q.pop_front();
        if (out_dat !== p.dat || out_sof !== p.sof) begin
          errors++;
          $display("FAIL payload[%s]: got dat=%h sof=%b, wanted dat=%h sof=%b",
                   p.tag, out_dat, out_sof, p.dat, p.sof);
        end
      end
    end
    if (out_eof) begin
      checks++;
      if (eof_q.size() == 0) begin
        errors++;
        $display("FAIL eof_extra: got good=%b len=%0d err=%b, wanted no eof", out_good, out_len, out_err);
      end else begin
        e = eof_q.pop_front();
        if (exp_q.size() != 0 && exp_q[0].tag == e.tag) begin
          errors++;
          $display("FAIL eof_early[%s]: got eof with %0d bytes pending, wanted 0", e.tag, exp_q.size());
        end
        if (out_good !== e.good || out_len !== e.len || out_err !== e.err) begin
          errors++;
          $display("FAIL eof[%s]: got good=%b len=%0d err=%b, wanted good=%b len=%0d err=%b",
                   e.tag, out_good, out_len, out_err, e.good, e.len, e.err);
        end
      end
    end
    if (out_val && out_eof) begin
      errors++;
      $display("FAIL val_eof_overlap: got val=1 eof=1, wanted not both");
    end
  end

  initial begin
    bq_t pl;
    bq_t fr;
    pay_t p;

    vecs[0] = '{"good_ascii",  9, 7, 1'b1, 1'b0, -1,  9, 1'b1,  9, 3'b000};
    vecs[1] = '{"fcs_bad",     9, 7, 1'b1, 1'b1, -1,  9, 1'b0,  9, 3'b001};
    vecs[2] = '{"phy_err3",    9, 7, 1'b1, 1'b0,  3,  9, 1'b0,  9, 3'b010};
    vecs[3] = '{"rand20",     20, 7, 1'b0, 1'b0, -1, 20, 1'b1, 20, 3'b000};
    vecs[4] = '{"pre1",        5, 1, 1'b0, 1'b0, -1,  5, 1'b1,  5, 3'b000};
    vecs[5] = '{"min_frame",   0, 7, 1'b0, 1'b0, -1,  0, 1'b1,  0, 3'b000};
    vecs[6] = '{"at_max_len", 46, 7, 1'b0, 1'b0, -1, 46, 1'b1, 46, 3'b000};
    vecs[7] = '{"over_len",   56, 7, 1'b0, 1'b0, -1, 46, 1'b0, 46, 3'b100};
    vecs[8] = '{"over_len_err", 56, 7, 1'b0, 1'b0, 50, 46, 1'b0, 46, 3'b110};

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Literal reference frame "123456789" with its known FCS bytes
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    fr = {};
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    foreach (pl[i]) fr.push_back(pl[i]);
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    expect_frame(pl, 9, 1'b1, 9, 3'b000, "ref_good");
    send(fr, -1, 2);
    fr[fr.size()-1] = 8'hCA;
    expect_frame(pl, 9, 1'b0, 9, 3'b001, "ref_badfcs");
    send(fr, -1, 2);

    // Table-driven frames
    for (int v = 0; v < 9; v++) begin
      pl = {};
      for (int i = 0; i < vecs[v].plen; i++)
        pl.push_back(vecs[v].ascii ? 8'h31 + 8'(i) : 8'($urandom));
      fr = build(pl, vecs[v].npre, vecs[v].corrupt);
      expect_frame(pl, vecs[v].n_emit, vecs[v].good, vecs[v].len, vecs[v].err, vecs[v].name);
      send(fr, (vecs[v].err_pos < 0) ? -1 : vecs[v].npre + 1 + vecs[v].err_pos, 2);
    end

    // Runt: two post-SFD bytes
    fr = {};
    repeat (7) fr.push_back(8'h55);
    fr.push_back(8'hD5); fr.push_back(8'hAA); fr.push_back(8'hBB);
    pl = {};
    expect_frame(pl, 0, 1'b0, 0, 3'b010, "runt");
    send(fr, -1, 2);

    // Bad preamble byte
    fr = {};
    fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h12);
    fr.push_back(8'h34); fr.push_back(8'h56);
    expect_frame(pl, 0, 1'b0, 0, 3'b010, "bad_pre");
    send(fr, -1, 2);

    // Preamble one byte too long
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    fr = build(pl, 8, 1'b0);
    pl = {};
    expect_frame(pl, 0, 1'b0, 0, 3'b010, "long_pre");
    send(fr, -1, 2);

    // Preamble with no SFD is silent
    fr = {};
    repeat (3) fr.push_back(8'h55);
    send(fr, -1, 2);

    // Back-to-back good frames with a single idle cycle
    for (int k = 0; k < 2; k++) begin
      pl = {};
      for (int i = 0; i < 12; i++) pl.push_back(8'($urandom));
      fr = build(pl, 7, 1'b0);
      expect_frame(pl, 12, 1'b1, 12, 3'b000, (k == 0) ? "b2b_a" : "b2b_b");
      send(fr, -1, 1);
    end
    repeat (2) begin @(posedge clk); #1; end

    // Reset for one cycle mid-payload, line kept busy
    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    fr = build(pl, 7, 1'b0);
    for (int i = 0; i < 6; i++) begin
      p.dat = pl[i];
      p.sof = (i == 0);
      p.tag = "pre_reset";
      exp_q.push_back(p);
    end
    for (int i = 0; i < 18; i++) begin
      phy_val = 1'b1; phy_dat = fr[i]; phy_err = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b0; phy_dat = fr[18];
    @(posedge clk); #1;
    check_zero("mid_reset");
    rst = 1'b1;
    for (int i = 19; i < 22; i++) begin
      phy_dat = fr[i];
      @(posedge clk); #1;
    end
    phy_val = 1'b0; phy_dat = 8'h00;
    repeat (2) begin @(posedge clk); #1; end
    pl = {};
    for (int i = 0; i < 15; i++) pl.push_back(8'($urandom));
    fr = build(pl, 7, 1'b0);
    expect_frame(pl, 15, 1'b1, 15, 3'b000, "post_reset");
    send(fr, -1, 2);

    // Drain and confirm nothing is left outstanding
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0 || eof_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes and %0d eofs outstanding, wanted 0 and 0",
               exp_q.size(), eof_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
